// File: rtl/sram_stream_reader_if.sv
// Output stream bundle of the SRAM reader: word, last-beat marker, valid/ready.
// Latency: none, this is wiring only.
// Backpressure: the consumer holds m_ready low, and the producer then keeps m_data/m_last stable.
interface sram_stream_reader_if #(
    parameter int DW = 32
);
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/sram_stream_reader.sv
// Reads len words from the SRAM starting at base_addr and streams them out in order, flagging the last word.
// Latency: start in cycle 0, first read in cycle 1, SRAM data in cycle 2, first beat valid in cycle 3.
// Backpressure: reads are held off while buffered plus in-flight words would exceed FIFO_DEPTH, so no word is dropped.
module sram_stream_reader #(
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = 13,
    parameter int DW         = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [AW-1:0]        base_addr,
    input  logic [AW:0]          len,
    output logic                 busy,
    output logic                 done,
    output logic                 sram_csbn,
    output logic [AW-1:0]        sram_raddr,
    output logic                 sram_wsbn,
    output logic [AW-1:0]        sram_waddr,
    output logic [DW-1:0]        sram_wdata,
    input  logic [DW-1:0]        sram_rdata,
    sram_stream_reader_if.master m
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] MAX_LEN = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic            done_q, done_d;
    logic [AW-1:0]   base_q, base_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   issued_q, issued_d;
    logic [LW-1:0]   beats_q, beats_d;
    logic            rvalid_q;

    logic [DW-1:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   count_q;

    logic [LW-1:0]   len_clamped;
    logic [CW:0]     occupancy;
    logic            fifo_has_room;
    logic            issue;
    logic            push;
    logic            pop;
    logic            m_valid_w;
    logic            m_last_w;

    // Requests above the memory size are served as a full-memory read.
    assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;

    // A read issued now lands one cycle later, so the word still in flight reserves a slot too.
    // Pops in the current cycle are deliberately not credited, keeping the issue path off m_ready.
    assign occupancy     = {1'b0, count_q} + {{CW{1'b0}}, rvalid_q};
    assign fifo_has_room = occupancy < (CW + 1)'(FIFO_DEPTH);

    assign push      = rvalid_q;
    assign m_valid_w = (count_q != '0);
    assign pop       = m_valid_w && m.m_ready;
    assign m_last_w  = m_valid_w && (beats_q == len_q - LW'(1));

    // Command sequencing and read issue; done is registered so it lands the cycle after completion.
    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        base_d   = base_q;
        len_d    = len_q;
        issued_d = issued_q;
        beats_d  = beats_q;
        issue    = 1'b0;

        if (pop) begin
            beats_d = beats_q + LW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                // done_q high means busy is still reported, so a start in that cycle is ignored.
                if (start && !done_q) begin
                    base_d   = base_addr;
                    len_d    = len_clamped;
                    issued_d = '0;
                    beats_d  = '0;
                    if (len_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                issue = (issued_q < len_q) && fifo_has_room;
                if (issue) begin
                    issued_d = issued_q + LW'(1);
                end
                if (issued_d == len_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Popping the final beat leaves the FIFO empty with nothing in flight.
                if (pop && m_last_w) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state, command registers and the read-return tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            done_q   <= 1'b0;
            base_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            beats_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            base_q   <= base_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            beats_q  <= beats_d;
            rvalid_q <= issue;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents are only observed through the count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= sram_rdata;
        end
    end

    assign busy       = (state_q != ST_IDLE) || done_q;
    assign done       = done_q;
    assign sram_csbn  = !issue;
    assign sram_raddr = base_q + issued_q[AW-1:0];
    assign sram_wsbn  = 1'b1;
    assign sram_waddr = '0;
    assign sram_wdata = '0;

    // Data is gated by valid so the port shows zero when empty; it is stable while stalled.
    assign m.m_valid = m_valid_w;
    assign m.m_data  = m_valid_w ? mem_q[rptr_q] : '0;
    assign m.m_last  = m_last_w;

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_sram_stream_reader.sv
`timescale 1ns/1ps
module tb_sram_stream_reader;
    localparam int AW    = 13;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int MEMW  = 1 << AW;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, sram_csbn, sram_wsbn;
    logic [AW-1:0] sram_raddr, sram_waddr;
    logic [DW-1:0] sram_wdata, sram_rdata;

    sram_stream_reader_if #(.DW(DW)) s();

    sram_stream_reader #(.FIFO_DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .sram_csbn  (sram_csbn),
        .sram_raddr (sram_raddr),
        .sram_wsbn  (sram_wsbn),
        .sram_waddr (sram_waddr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .m          (s)
    );

    always #5 clk = ~clk;

    // SRAM macro model: one-cycle read latency.
    logic [DW-1:0] mem [MEMW];
    always @(posedge clk) if (!sram_csbn) sram_rdata <= mem[sram_raddr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_err = 0;
    beat_t exp_q[$];
    int    addr_q[$];
    int    rd_total = 0, pop_total = 0, done_total = 0, n_acc = 0, t0 = 0;
    int    ready_mode = 0;   // 0 always ready, 1 random, 2 held low

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference: a command reads min(len, memory size) consecutive words, address wrapping mod memory size.
    task automatic push_expect(input int b, input int l);
        int n;
        n = (l > MEMW) ? MEMW : l;
        for (int i = 0; i < n; i++) begin
            int a;
            beat_t e;
            a = (b + i) % MEMW;
            e.d = mem[a];
            e.l = (i == n - 1);
            addr_q.push_back(a);
            exp_q.push_back(e);
        end
    endtask

    // Consumer ready driver.
    initial begin
        s.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       s.m_ready = 1'b1;
                1:       s.m_ready = 1'($urandom_range(0, 1));
                default: s.m_ready = 1'b0;
            endcase
        end
    end

    // Monitor: checks read addresses, outstanding reads, stream beats, stall stability and done pulses.
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data;
    logic          stall_last;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (!sram_csbn) begin
                rd_total++;
                if (addr_q.size() == 0) fail_now("unexpected_sram_read");
                else chk("sram_raddr", sram_raddr, addr_q.pop_front());
                chk("outstanding_le_depth", (rd_total - pop_total) <= DEPTH, 1);
                chk("sram_wsbn", sram_wsbn, 1);
            end
            if (stall_prev) begin
                chk("stall_valid_held", s.m_valid, 1);
                chk("stall_data_stable", s.m_data, stall_data);
                chk("stall_last_stable", s.m_last, stall_last);
            end
            if (s.m_valid && s.m_ready) begin
                pop_total++;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("m_data", s.m_data, e.d);
                    chk("m_last", s.m_last, e.l);
                end
            end
            stall_prev = s.m_valid && !s.m_ready;
            stall_data = s.m_data;
            stall_last = s.m_last;
            if (done) done_total++;
        end
    end

    // Call at a drive point; returns at the drive point of cycle 1.
    task automatic issue_cmd(input int b, input int l);
        start     = 1'b1;
        base_addr = AW'(b);
        len       = (AW + 1)'(l);
        push_expect(b, l);
        t0 = cyc;
        n_acc++;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit junk, input int budget, output int rel);
        bit got;
        int n;
        got = 1'b0;
        n   = 0;
        rel = -1;
        while (!got && n < budget) begin
            if (junk && $urandom_range(0, 3) == 0) begin
                start     = 1'b1;
                base_addr = AW'($urandom);
                len       = (AW + 1)'($urandom_range(1, 64));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                rel = cyc - t0;
                chk("busy_at_done", busy, 1);
                chk("beats_left_at_done", exp_q.size(), 0);
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        if (!got) fail_now("done_timeout");
        else chk("busy_after_done", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int rel, rd0, p0, n, b, l;

        for (int i = 0; i < MEMW; i++) mem[i] = DW'(i + 32'h100);

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_csbn", sram_csbn, 1);
        chk("rst_raddr", sram_raddr, 0);
        chk("rst_m_valid", s.m_valid, 0);
        chk("rst_m_last", s.m_last, 0);
        chk("rst_m_data", s.m_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic cycle-exact read: base 0x010, len 4.
        start = 1'b1; base_addr = 13'h010; len = 14'd4;
        push_expect(32'h010, 4);
        t0 = cyc;
        n_acc++;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            chk("basic_csbn", sram_csbn, !(k >= 1 && k <= 4));
            chk("basic_m_valid", s.m_valid, (k >= 3 && k <= 6));
            if (k >= 3 && k <= 6) chk("basic_m_data", s.m_data, 32'h110 + k - 3);
            chk("basic_m_last", s.m_last, (k == 6));
            chk("basic_done", done, (k == 7));
            chk("basic_busy", busy, (k >= 1 && k <= 7));
        end
        @(posedge clk);
        #1;

        // Address wrap-around.
        issue_cmd(32'h1FFE, 4);
        wait_done(1'b0, 200, rel);
        chk("wrap_done_cycle", rel, 7);

        // Zero-length command.
        issue_cmd(32'h123, 0);
        wait_done(1'b0, 20, rel);
        chk("len0_done_cycle", rel, 1);

        for (int i = 0; i < MEMW; i++) mem[i] = $urandom;

        // Backpressure: ready held low for 10 cycles.
        ready_mode = 2;
        @(posedge clk);
        #1;
        rd0 = rd_total;
        issue_cmd(32'h0A0, 16);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("bp_reads_issued", rd_total - rd0, DEPTH);
        chk("bp_m_valid", s.m_valid, 1);
        ready_mode = 0;
        wait_done(1'b0, 500, rel);

        // Reset during the 5th beat.
        issue_cmd(32'h0300, 32);
        p0 = pop_total;
        n  = 0;
        while (pop_total - p0 < 4 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (pop_total - p0 < 4) fail_now("reset_test_beats_timeout");
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_csbn", sram_csbn, 1);
        chk("midrst_raddr", sram_raddr, 0);
        chk("midrst_m_valid", s.m_valid, 0);
        chk("midrst_m_last", s.m_last, 0);
        chk("midrst_m_data", s.m_data, 0);
        exp_q.delete();
        addr_q.delete();
        rd_total  = 0;
        pop_total = 0;
        n_acc--;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue_cmd(32'h0400, 8);
        wait_done(1'b0, 200, rel);
        chk("post_reset_done_cycle", rel, 11);

        // Random commands with random ready and ignored starts while busy.
        ready_mode = 1;
        for (int c = 0; c < 200; c++) begin
            b = int'($urandom_range(0, MEMW - 1));
            l = int'($urandom_range(1, 64));
            issue_cmd(b, l);
            wait_done(1'b1, 64 * 40 + 200, rel);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
        end

        // Full-memory read and oversize clamp.
        ready_mode = 0;
        @(posedge clk);
        #1;
        issue_cmd(int'($urandom_range(0, MEMW - 1)), MEMW);
        wait_done(1'b0, MEMW + 200, rel);
        chk("full_mem_done_cycle", rel, MEMW + 3);
        issue_cmd(32'h0005, 16383);
        wait_done(1'b0, MEMW + 200, rel);
        chk("clamp_done_cycle", rel, MEMW + 3);

        repeat (4) @(posedge clk);
        #1;
        chk("done_pulse_count", done_total, n_acc);
        chk("beats_left_end", exp_q.size(), 0);
        chk("reads_left_end", addr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
